// File: rtl/fullchip_pwr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fullchip_pwr_seq_pkg
// Brief    : State encoding and default phase lengths for the power sequencer.
// Revision : 1.0
// ============================================================================
package fullchip_pwr_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_PWR1 = 3'd2,
        ST_PWR2 = 3'd3,
        ST_POR  = 3'd4,
        ST_REL  = 3'd5,
        ST_RUN  = 3'd6,
        ST_DOWN = 3'd7
    } state_t;

    localparam int unsigned c_DEF_CNT_W    = 16;
    localparam int unsigned c_DEF_PRE_CYC  = 5;
    localparam int unsigned c_DEF_PWR1_CYC = 20;
    localparam int unsigned c_DEF_PWR2_CYC = 20;
    localparam int unsigned c_DEF_POR_CYC  = 50;
    localparam int unsigned c_DEF_REL_CYC  = 10;
    localparam int unsigned c_DEF_DOWN_CYC = 20;

endpackage
`default_nettype wire

// File: rtl/fullchip_pwr_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fullchip_pwr_seq_if
// Brief    : Control inputs and supply/reset outputs of the power sequencer.
// Revision : 1.0
// ============================================================================
interface fullchip_pwr_seq_if;

    logic       start;
    logic       restart;
    logic       power1;
    logic       power2;
    logic       por_n;
    logic       rstb;
    logic       done;
    logic       busy;
    logic [2:0] state;

    modport master (
        output start,
        output restart,
        input  power1,
        input  power2,
        input  por_n,
        input  rstb,
        input  done,
        input  busy,
        input  state
    );

    modport slave (
        input  start,
        input  restart,
        output power1,
        output power2,
        output por_n,
        output rstb,
        output done,
        output busy,
        output state
    );

endinterface
`default_nettype wire

// File: rtl/fullchip_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module   : fullchip_pwr_seq
// Brief    : Cycle-accurate supply/POR/resetb sequencer with power-down restart.
// Revision : 1.0
// ============================================================================
module fullchip_pwr_seq
    import fullchip_pwr_seq_pkg::*;
#(
    parameter int unsigned CNT_W      = c_DEF_CNT_W,
    parameter int unsigned PRE_CYC    = c_DEF_PRE_CYC,
    parameter int unsigned PWR1_CYC   = c_DEF_PWR1_CYC,
    parameter int unsigned PWR2_CYC   = c_DEF_PWR2_CYC,
    parameter int unsigned POR_CYC    = c_DEF_POR_CYC,
    parameter int unsigned REL_CYC    = c_DEF_REL_CYC,
    parameter int unsigned DOWN_CYC   = c_DEF_DOWN_CYC,
    parameter bit          AUTO_START = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fullchip_pwr_seq_if.slave  bus
);

    localparam longint unsigned c_LIMIT = 64'd1 << CNT_W;

    if ((64'(PRE_CYC)  >= c_LIMIT) || (64'(PWR1_CYC) >= c_LIMIT) ||
        (64'(PWR2_CYC) >= c_LIMIT) || (64'(POR_CYC)  >= c_LIMIT) ||
        (64'(REL_CYC)  >= c_LIMIT) || (64'(DOWN_CYC) >= c_LIMIT)) begin : g_cyc_range_err
        $error("fullchip_pwr_seq: a phase length does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] c_PRE  = CNT_W'(PRE_CYC);
    localparam logic [CNT_W-1:0] c_PWR1 = CNT_W'(PWR1_CYC);
    localparam logic [CNT_W-1:0] c_PWR2 = CNT_W'(PWR2_CYC);
    localparam logic [CNT_W-1:0] c_POR  = CNT_W'(POR_CYC);
    localparam logic [CNT_W-1:0] c_REL  = CNT_W'(REL_CYC);
    localparam logic [CNT_W-1:0] c_DOWN = CNT_W'(DOWN_CYC);

    state_t           r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [CNT_W-1:0] w_lim;
    logic             w_at_lim;
    logic             r_power1, w_power1_nxt;
    logic             r_power2, w_power2_nxt;
    logic             r_por_n,  w_por_n_nxt;
    logic             r_rstb,   w_rstb_nxt;
    logic             r_done,   w_done_nxt;
    logic             r_busy,   w_busy_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_power1 <= 1'b0;
            r_power2 <= 1'b0;
            r_por_n  <= 1'b1;
            r_rstb   <= 1'b1;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_power1 <= w_power1_nxt;
            r_power2 <= w_power2_nxt;
            r_por_n  <= w_por_n_nxt;
            r_rstb   <= w_rstb_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    always_comb begin
        case (r_state)
            ST_PRE:  w_lim = c_PRE;
            ST_PWR1: w_lim = c_PWR1;
            ST_PWR2: w_lim = c_PWR2;
            ST_POR:  w_lim = c_POR;
            ST_REL:  w_lim = c_REL;
            ST_DOWN: w_lim = c_DOWN;
            default: w_lim = '0;
        endcase
    end

    assign w_at_lim = (r_cnt == w_lim);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_power1_nxt = r_power1;
        w_power2_nxt = r_power2;
        w_por_n_nxt  = r_por_n;
        w_rstb_nxt   = r_rstb;
        w_done_nxt   = r_done;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt    = '0;
                w_power1_nxt = 1'b0;
                w_power2_nxt = 1'b0;
                w_por_n_nxt  = 1'b1;
                w_rstb_nxt   = 1'b1;
                w_done_nxt   = 1'b0;
                if (bus.start || AUTO_START) begin
                    w_state_nxt = ST_PRE;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = '0;
                if (bus.restart) begin
                    w_state_nxt  = ST_DOWN;
                    w_rstb_nxt   = 1'b0;
                    w_done_nxt   = 1'b0;
                    w_power2_nxt = 1'b0;
                end
            end
            ST_DOWN: begin
                if (w_at_lim) begin
                    w_state_nxt  = ST_IDLE;
                    w_cnt_nxt    = '0;
                    w_power1_nxt = 1'b0;
                    w_por_n_nxt  = 1'b1;
                    w_rstb_nxt   = 1'b1;
                end
            end
            default: begin
                // Power-up phases: an abort takes priority over the phase exit.
                if (bus.restart) begin
                    w_state_nxt  = ST_DOWN;
                    w_cnt_nxt    = '0;
                    w_rstb_nxt   = 1'b0;
                    w_done_nxt   = 1'b0;
                    w_power2_nxt = 1'b0;
                end else if (w_at_lim) begin
                    w_cnt_nxt = '0;
                    case (r_state)
                        ST_PRE: begin
                            w_state_nxt = ST_PWR1;
                            w_rstb_nxt  = 1'b0;
                            w_por_n_nxt = 1'b0;
                        end
                        ST_PWR1: begin
                            w_state_nxt  = ST_PWR2;
                            w_power1_nxt = 1'b1;
                        end
                        ST_PWR2: begin
                            w_state_nxt  = ST_POR;
                            w_power2_nxt = 1'b1;
                        end
                        ST_POR: begin
                            w_state_nxt = ST_REL;
                            w_por_n_nxt = 1'b1;
                        end
                        default: begin
                            w_state_nxt = ST_RUN;
                            w_rstb_nxt  = 1'b1;
                            w_done_nxt  = 1'b1;
                        end
                    endcase
                end
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_RUN);
    end

    assign bus.power1 = r_power1;
    assign bus.power2 = r_power2;
    assign bus.por_n  = r_por_n;
    assign bus.rstb   = r_rstb;
    assign bus.done   = r_done;
    assign bus.busy   = r_busy;
    assign bus.state  = r_state;

    a_pwr_order: assert property (@(posedge clk) disable iff (rst)
        r_power2 |-> r_power1);

    a_done_ok: assert property (@(posedge clk) disable iff (rst)
        r_done |-> (r_power1 && r_power2 && r_rstb && r_por_n));

endmodule
`default_nettype wire

// File: doc/fullchip_pwr_seq.md
Name: fullchip_pwr_seq

Overview:
- Cycle-based power/reset sequencer for the full-chip bench.
- Drives the supply enables (power1 = 3V3 domain, power2 = 1V8 domain), the POR internal node and the chip resetb, with configurable phase lengths.
- Replaces ad-hoc `initial` delay sequencing, so event-driven and cycle-based simulators see identical, clock-accurate sequencing.
- Supports power-down/restart of the chip mid-test.

Parameters:
- CNT_W, 16, phase counter width. Every *_CYC value must be < 2**CNT_W; otherwise an elaboration-time error.
- PRE_CYC, 5, cycles-1 held in PRE before asserting reset.
- PWR1_CYC, 20, cycles-1 in PWR1 before power1 rises.
- PWR2_CYC, 20, cycles-1 in PWR2 before power2 rises.
- POR_CYC, 50, cycles-1 in POR before por_n rises.
- REL_CYC, 10, cycles-1 in REL before reset release.
- DOWN_CYC, 20, cycles-1 in DOWN between power2 and power1 falling.
- AUTO_START, 1, 1 = leave IDLE without start.

Ports:
- clk      in   1  sequencer clock
- rst      in   1  asynchronous, active-high reset
- start    in   1  begin power-up sequence (sampled in IDLE only)
- restart  in   1  power down and return to IDLE
- power1   out  1  3V3 supply enable
- power2   out  1  1V8 supply enable
- por_n    out  1  drive for the POR internal node
- rstb     out  1  chip resetb (active low)
- done     out  1  chip powered and out of reset
- busy     out  1  state is neither IDLE nor RUN
- state    out  3  current state encoding

Behaviour:
- Reset is asynchronous and active-high.
- All outputs are registered.
- Reset values: state=IDLE, cnt=0, power1=0, power2=0, por_n=1, rstb=1, done=0, busy=0.
- Phase rule:
  - On entering a timed state, cnt=0.
  - Each clock in that state: if cnt==N the state's actions apply and the state advances (cnt cleared); else cnt++.
  - A state therefore lasts N+1 cycles. N=0 gives a 1-cycle phase.
- Encoding: IDLE=0, PRE=1, PWR1=2, PWR2=3, POR=4, REL=5, RUN=6, DOWN=7.
- IDLE: outputs hold reset values. If start, or AUTO_START=1 → PRE. In IDLE, AUTO_START=1 is re-evaluated every cycle.
- PRE (N=PRE_CYC): exit → rstb<=0, por_n<=0 (this 1→0 edge is the power-on negedge), → PWR1.
- PWR1 (PWR1_CYC): exit → power1<=1, → PWR2.
- PWR2 (PWR2_CYC): exit → power2<=1, → POR.
- POR (POR_CYC): exit → por_n<=1, → REL.
- REL (REL_CYC): exit → rstb<=1, done<=1, → RUN.
- RUN: hold all outputs indefinitely. restart → DOWN with rstb<=0, done<=0, power2<=0 on the same edge.
- DOWN (DOWN_CYC): exit → power1<=0, por_n<=1, rstb<=1, → IDLE.
- Restart from PRE, PWR1, PWR2, POR or REL aborts the sequence: → DOWN with the same entry actions as from RUN.
- restart in IDLE or DOWN is ignored.
- start outside IDLE is ignored.
- start and restart in the same cycle: in IDLE, start wins; elsewhere, restart wins.
- busy = (state != IDLE && state != RUN), registered with the state.
- rst asserted mid-sequence: immediate return to reset values (power drops at once); no DOWN phase.
- Invariants (assertions):
  - power2 implies power1.
  - done implies power1 && power2 && rstb && por_n.

Decomposition:
- Package fullchip_pwr_seq_pkg:
  - state encoding constants, 3 bits;
  - default phase-length constants.
- No sub-module. Counter and FSM are inline in one always block plus output registers; about 150 lines.

Test Plan:
- Defaults, AUTO_START=1; rst released before edge E0. State=PRE after E0; rstb/por_n=0 after E6; power1=1 after E27; power2=1 after E48; por_n=1 after E99; rstb=1 and done=1 after E110; busy high E0..E109.
- AUTO_START=0, start pulsed 1 cycle at E50. Outputs hold reset values until E50; the sequence then matches the previous case offset by 50 (done after E160).
- From RUN, restart at edge Er. done=0, rstb=0, power2=0 after Er; power1=0, rstb=1, por_n=1 after Er+21; state=IDLE; with AUTO_START=1, PRE after Er+22.
- restart during POR (cnt=10). DOWN is entered the next edge; done never asserts; power2=0 at once, power1=0 after 21 cycles.
- rst pulsed while in PWR2. Outputs return to reset values asynchronously, before the next clock; after release the sequence restarts from IDLE with full timing.
- All *_CYC=0. PRE/PWR1/PWR2/POR/REL last 1 cycle each; done=1 after E5 relative to PRE entry at E0.
